// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide RAM port between a fetch and a data requester,
// serialising word/halfword/byte accesses big-endian with data-side priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_rw,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              busy,
  output logic              grant_dm
);
  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, last_q, last_d;
  logic own_dm_q, own_dm_d, rw_q, rw_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d, if_rd_q, if_rd_d, dm_rd_q, dm_rd_d;
  logic [23:0] asm_q, asm_d;
  logic xfer;
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= '0;
      own_dm_q <= 1'b0;
      rw_q     <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      if_rd_q  <= '0;
      dm_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      own_dm_q <= own_dm_d;
      rw_q     <= rw_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      asm_q    <= asm_d;
      if_rd_q  <= if_rd_d;
      dm_rd_q  <= dm_rd_d;
    end
  end
  // last_q holds N-1; the assembly register shifts bytes in so the first byte lands highest
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    own_dm_d = own_dm_q;
    rw_d     = rw_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    asm_d    = asm_q;
    if_rd_d  = if_rd_q;
    dm_rd_d  = dm_rd_q;
    case (state_q)
      IDLE: if (dm_req || if_req) begin
        state_d  = XFER;
        cnt_d    = '0;
        own_dm_d = dm_req;
        rw_d     = dm_req & dm_rw;
        last_d   = !dm_req ? 2'd3 : dm_size == 2'd0 ? 2'd0 : dm_size == 2'd1 ? 2'd1 : 2'd3;
        base_d   = dm_req ? dm_addr : if_addr;
        wdata_d  = dm_wdata;
        asm_d    = '0;
      end
      XFER: begin
        if (!rw_q) asm_d = {asm_q[15:0], ram_rdata};
        if (cnt_q == last_q) begin
          state_d = ACK;
          if (!rw_q && own_dm_q) dm_rd_d = {asm_q, ram_rdata};
          if (!rw_q && !own_dm_q) if_rd_d = {asm_q, ram_rdata};
        end else cnt_d = cnt_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    xfer      = state_q == XFER;
    ram_en    = xfer;
    ram_we    = xfer & rw_q;
    ram_addr  = xfer ? base_q + ADDR_W'(cnt_q) : '0;
    ram_wdata = (xfer & rw_q) ? 8'(wdata_q >> {last_q - cnt_q, 3'b000}) : 8'h00;
    if_ack    = state_q == ACK && !own_dm_q;
    dm_ack    = state_q == ACK && own_dm_q;
    busy      = state_q != IDLE;
    grant_dm  = busy & own_dm_q;
    if_rdata  = if_rd_q;
    dm_rdata  = dm_rd_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a byte-array
// RAM and a transaction-level reference model.
module tb_mem_port_arbiter;
  logic        CLK, CLR;
  logic        if_req, dm_req, dm_rw;
  logic [7:0]  if_addr, dm_addr;
  logic [1:0]  dm_size;
  logic [31:0] dm_wdata, if_rdata, dm_rdata;
  logic        if_ack, dm_ack, ram_en, ram_we, busy, grant_dm;
  logic [7:0]  ram_addr, ram_wdata, ram_rdata;
  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic        preload;
  logic [31:0] exp_if, exp_dm;
  int ncmp = 0, nerr = 0;

  mem_port_arbiter #(.ADDR_W(8)) dut (
    .CLK(CLK), .CLR(CLR), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .grant_dm(grant_dm)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign ram_rdata = mem[ram_addr];
  always @(posedge CLK)
    if (preload) mem <= ref_mem;
    else if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the owner's req already raised and the block idle.
  task automatic run(input bit dm, input bit rw, input logic [1:0] sz, input logic [7:0] a,
                     input logic [31:0] wd, input bit drop);
    int n;
    logic [31:0] exp_rd;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    exp_rd = '0;
    for (int k = 0; k < n; k++) exp_rd[8*(n-1-k) +: 8] = ref_mem[8'(a + k)];
    @(posedge CLK);
    @(negedge CLK);
    for (int k = 0; k < n; k++) begin
      chk("ram_en", ram_en, 1);
      chk("ram_addr", ram_addr, 8'(a + k));
      chk("ram_we", ram_we, rw);
      chk("grant_dm", grant_dm, dm);
      chk("busy_xfer", busy, 1);
      chk("ack_early", {if_ack, dm_ack}, 0);
      if (rw) begin
        chk("ram_wdata", ram_wdata, wd[8*(n-1-k) +: 8]);
        ref_mem[8'(a + k)] = wd[8*(n-1-k) +: 8];
      end
      if (drop && k == 0) begin
        if (dm) dm_req = 1'b0;
        else if_req = 1'b0;
      end
      @(negedge CLK);
    end
    if (!rw) begin
      if (dm) exp_dm = exp_rd;
      else exp_if = exp_rd;
    end
    chk("ack", {if_ack, dm_ack}, dm ? 2'b01 : 2'b10);
    chk("ram_en_ack", {ram_en, ram_we}, 0);
    chk("if_rdata", if_rdata, exp_if);
    chk("dm_rdata", dm_rdata, exp_dm);
    if (dm) dm_req = 1'b0;
    else if_req = 1'b0;
    @(negedge CLK);
    chk("idle", {busy, if_ack, dm_ack, ram_en, ram_we}, 0);
    chk("idle_ram", {ram_addr, ram_wdata}, 0);
  endtask

  initial begin
    int diffs;
    bit dm, rw, drop;
    logic [1:0] sz;
    logic [7:0] a;
    logic [31:0] wd;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    {ref_mem[8'h10], ref_mem[8'h11], ref_mem[8'h12], ref_mem[8'h13]} = 32'hE3A01005;
    ref_mem[8'h40] = 8'h7F;
    {ref_mem[8'hFE], ref_mem[8'hFF], ref_mem[8'h00], ref_mem[8'h01]} = 32'h11223344;
    {ref_mem[8'h32], ref_mem[8'h33]} = 16'h5A6B;
    preload = 1'b1;
    CLR = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; dm_rw = 1'b1; dm_size = 2'd2;
    if_addr = 8'h10; dm_addr = 8'h20; dm_wdata = 32'hFFFFFFFF;
    exp_if = '0; exp_dm = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ctl", {if_ack, dm_ack, ram_en, ram_we, busy, grant_dm}, 0);
    chk("rst_ram", {ram_addr, ram_wdata}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    preload = 1'b0;
    if_req = 1'b0; dm_req = 1'b0;
    CLR = 1'b1;
    @(negedge CLK);

    if_addr = 8'h10; if_req = 1'b1;
    run(0, 0, 2'd2, 8'h10, 0, 0);
    chk("fetch_word", if_rdata, 32'hE3A01005);

    dm_rw = 1'b0; dm_size = 2'd0; dm_addr = 8'h40; dm_req = 1'b1;
    if_addr = 8'h10; if_req = 1'b1;
    run(1, 0, 2'd0, 8'h40, 0, 0);
    chk("contend_dm", dm_rdata, 32'h0000007F);
    run(0, 0, 2'd2, 8'h10, 0, 0);
    chk("contend_if", if_rdata, 32'hE3A01005);

    dm_rw = 1'b1; dm_size = 2'd1; dm_addr = 8'h21; dm_wdata = 32'h1234BEEF; dm_req = 1'b1;
    run(1, 1, 2'd1, 8'h21, 32'h1234BEEF, 0);
    chk("hw_mem", {mem[8'h21], mem[8'h22]}, 16'hBEEF);
    chk("hw_rdata", dm_rdata, 32'h0000007F);

    dm_rw = 1'b0; dm_size = 2'd3; dm_addr = 8'hFE; dm_req = 1'b1;
    run(1, 0, 2'd3, 8'hFE, 0, 0);
    chk("wrap_rdata", dm_rdata, 32'h11223344);

    dm_rw = 1'b1; dm_size = 2'd2; dm_addr = 8'h30; dm_wdata = 32'hA1B2C3D4; dm_req = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_b0", {ram_we, ram_addr, ram_wdata}, {1'b1, 8'h30, 8'hA1});
    @(negedge CLK);
    chk("abort_b1", {ram_we, ram_addr, ram_wdata}, {1'b1, 8'h31, 8'hB2});
    @(negedge CLK);
    CLR = 1'b0;
    #1;
    chk("abort_ctl", {ram_en, ram_we, busy, grant_dm, dm_ack, if_ack}, 0);
    chk("abort_rdata", {if_rdata, dm_rdata}, 0);
    ref_mem[8'h30] = 8'hA1;
    ref_mem[8'h31] = 8'hB2;
    exp_if = '0; exp_dm = '0;
    @(negedge CLK);
    chk("abort_noack", dm_ack, 0);
    chk("abort_mem", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, 32'hA1B25A6B);
    dm_rw = 1'b0; dm_size = 2'd0; dm_addr = 8'h31;
    CLR = 1'b1;
    run(1, 0, 2'd0, 8'h31, 0, 0);
    chk("after_abort", dm_rdata, 32'h000000B2);

    for (int i = 0; i < 40; i++) begin
      dm = 1'($urandom);
      rw = dm & 1'($urandom);
      sz = dm ? 2'($urandom) : 2'd2;
      a = 8'($urandom);
      wd = $urandom;
      drop = $urandom_range(0, 3) == 0;
      if (dm) begin
        dm_rw = rw; dm_size = sz; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
      end else begin
        if_addr = a; if_req = 1'b1;
      end
      run(dm, rw, sz, a, wd, drop);
    end

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("ram_image", diffs, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
